// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Holds the default PC width, reset/exception vectors, the default return-address-stack
// depth and the next-PC source selector used by the fetch PC generator.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SelExc,
    SelEret,
    SelRedir,
    SelHold,
    SelJump,
    SelJr,
    SelSeq
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for jal/jr prediction.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data as the new top (overwrites the oldest entry when full)
//   pop         - discard the top entry (ignored when empty)
//   push_data   - return address to push
//   clear       - drop all entries
//   top         - current top entry (valid only when empty is 0)
//   empty, full - occupancy flags
module pc_ras
  import cpu_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned DATA_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              clear,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [DATA_W-1:0] mem_q [RAS_DEPTH];
  // ptr_q is the next write slot; the top lives one below it. Depth is a power of two,
  // so pointer arithmetic wraps for free and a push while full lands on the oldest entry.
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_en;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[ptr_q] <= push_data;
    end
  end

  assign top   = mem_q[ptr_q - PtrW'(1)];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntMax);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC register plus a strict-priority next-PC mux, with a
// return-address stack predicting jr targets.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   stall               - hold PC, ignore ID-stage requests
//   exc_req             - exception: go to EXC_VEC and empty the RAS
//   eret_req, epc       - return from exception to epc
//   ex_redirect, ex_target - EX-stage redirect
//   id_jump, id_jal, id_jr, id_instr_index, id_pc - ID-stage control transfer info
//   pc                  - registered fetch PC
//   jr_pred             - RAS top (0 when empty), forwarded to EX for checking
//   ras_empty, ras_full - RAS occupancy flags
module pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
  parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              id_jump,
  input  logic              id_jal,
  input  logic              id_jr,
  input  logic [25:0]       id_instr_index,
  input  logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] jr_pred,
  output logic              ras_empty,
  output logic              ras_full
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4, id_pc_plus4, jump_tgt, next_raw;
  logic [ADDR_W-1:0] ras_top;
  logic              id_ok;
  logic              ras_push, ras_pop;
  pc_sel_e           sel;

  assign pc_plus4    = pc_q + ADDR_W'(4);
  assign id_pc_plus4 = id_pc + ADDR_W'(4);

  // J-format target keeps the upper bits of the delay-slot PC.
  always_comb begin
    jump_tgt       = id_pc_plus4;
    jump_tgt[27:0] = {id_instr_index, 2'b00};
  end

  always_comb begin
    sel = SelSeq;
    if (exc_req) begin
      sel = SelExc;
    end else if (eret_req) begin
      sel = SelEret;
    end else if (ex_redirect) begin
      sel = SelRedir;
    end else if (stall) begin
      sel = SelHold;
    end else if (id_jump || id_jal) begin
      sel = SelJump;
    end else if (id_jr && !ras_empty) begin
      sel = SelJr;
    end
  end

  always_comb begin
    next_raw = pc_plus4;
    unique case (sel)
      SelExc:   next_raw = EXC_VEC;
      SelEret:  next_raw = epc;
      SelRedir: next_raw = ex_target;
      SelHold:  next_raw = pc_q;
      SelJump:  next_raw = jump_tgt;
      SelJr:    next_raw = jr_pred;
      SelSeq:   next_raw = pc_plus4;
      default:  next_raw = pc_plus4;
    endcase
    pc_d = next_raw & ~ADDR_W'(3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // ID-stage RAS traffic only counts when nothing upstream overrides it.
  assign id_ok    = !(stall || ex_redirect || exc_req || eret_req);
  assign ras_push = id_ok && id_jal;
  // Pop exactly when the prediction is consumed; jal beats jr, empty jr is sequential.
  assign ras_pop  = (sel == SelJr);

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .DATA_W    (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (id_pc_plus4),
    .clear     (exc_req),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc      = pc_q;
  assign jr_pred = ras_empty ? '0 : ras_top;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/target width in bits (at least 28).
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_3000, meaning PC value after reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_4180, meaning exception entry address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, at least 2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port stall, input, 1 bit: hold the PC and ignore the ID-stage requests this cycle.
REQ-008 SHALL have port exc_req, input, 1 bit: exception taken this cycle.
REQ-009 SHALL have port eret_req, input, 1 bit: return from exception.
REQ-010 SHALL have port epc, input, ADDR_W bits: eret target.
REQ-011 SHALL have port ex_redirect, input, 1 bit: EX-resolved branch taken or jr mispredict.
REQ-012 SHALL have port ex_target, input, ADDR_W bits: EX redirect target.
REQ-013 SHALL have ports id_jump, id_jal and id_jr, each input, 1 bit: decoded in ID.
REQ-014 SHALL have port id_instr_index, input, 26 bits: J-format index field.
REQ-015 SHALL have port id_pc, input, ADDR_W bits: PC of the instruction in ID.
REQ-016 SHALL have port pc, output, ADDR_W bits: registered fetch PC.
REQ-017 SHALL have port jr_pred, output, ADDR_W bits: RAS top (prediction used for id_jr), passed to EX for checking.
REQ-018 SHALL have ports ras_empty and ras_full, each output, 1 bit: RAS occupancy flags.

Function
REQ-019 SHALL select the next PC by strict priority: exc_req -> EXC_VEC; eret_req -> epc; ex_redirect -> ex_target; stall -> pc (hold); id_jump or id_jal -> {id_pc_plus4[ADDR_W-1:28], id_instr_index, 2'b00} with id_pc_plus4 = id_pc+4; id_jr with RAS non-empty -> jr_pred; otherwise pc+4.
REQ-020 SHALL force bits [1:0] of every next-PC value to 0.
REQ-021 SHALL compute pc+4 and id_pc+4 modulo 2^ADDR_W, so that 0xFFFF_FFFC+4 = 0x0000_0000.
REQ-022 SHALL treat id_jr with the RAS empty as sequential (pc+4), without popping.
REQ-023 SHALL push id_pc+4 on id_jal; SHALL pop on id_jr; id_jal wins if both id_jal and id_jr are asserted.
REQ-024 SHALL suppress push and pop when stall, ex_redirect, exc_req or eret_req is asserted.
REQ-025 SHALL overwrite the oldest entry when a push occurs with the RAS full: pointer wraps modulo RAS_DEPTH and the count stays at RAS_DEPTH.
REQ-026 SHALL empty the RAS (count to 0) on exc_req.
REQ-027 SHALL make jr_pred combinational from the current top entry, and SHALL drive it to 0 when ras_empty is 1.
REQ-028 SHALL update the PC with 1-cycle latency: a request sampled at edge N is visible on pc after edge N.

Reset
REQ-029 SHALL, while rst_n is 0, immediately set pc = RESET_VEC, RAS count = 0, ras_empty = 1, ras_full = 0 and jr_pred = 0, independent of clk.
REQ-030 SHALL, on release of rst_n, advance from RESET_VEC at the first rising edge; reset asserted mid-stall or mid-redirect SHALL discard the pending request.

Structure
REQ-031 SHALL place ADDR_W, RESET_VEC and EXC_VEC defaults in a shared package, cpu_pkg.
REQ-032 SHALL implement the RAS as sub-module pc_ras (parameter RAS_DEPTH; ports push, pop, push_data, clear, top, empty, full).
REQ-033 SHALL be implemented as pc_gen holding only the PC register and the priority mux.

Verification
REQ-034 SHALL verify reset: release rst_n with no requests -> pc = 0x3000, 0x3004, 0x3008 on successive edges.
REQ-035 SHALL verify jal/jr: id_jal with id_pc = 0x3010 and index 0x0000C40 -> next pc = 0x3100 and push 0x3014; later id_jr -> pc = 0x3014 and ras_empty = 1.
REQ-036 SHALL verify priority: exc_req, ex_redirect (0x3200) and id_jump asserted together -> pc = 0x4180, no push, RAS cleared.
REQ-037 SHALL verify stall: stall together with id_jal -> pc held and no push; ex_redirect during stall -> pc = ex_target.
REQ-038 SHALL verify overflow: RAS_DEPTH+1 pushes of 0x10, 0x20, ... -> ras_full = 1 and pops return the newest RAS_DEPTH values, newest first.
REQ-039 SHALL verify wrap: pc = 0xFFFF_FFFC with no requests -> pc = 0x0000_0000; ex_target = 0x3203 -> pc = 0x3200.
